// File: rtl/macarray_pkg.sv
// Shared types and constants for the 8x8 int8 MAC array sequencing controller.
package macarray_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD_W = 3'd1,
      ST_STREAM = 3'd2,
      ST_DRAIN  = 3'd3,
      ST_WRITE  = 3'd4,
      ST_FIN    = 3'd5
   } state_t;

   localparam int MNT_M_LSB = 8;
   localparam int MNT_N_LSB = 4;
   localparam int MNT_T_LSB = 0;
   localparam int DIM_W     = 4;
   localparam int MAX_DIM   = 8;
   localparam int ADDR_O_W  = 4;

   function automatic logic dim_legal(input logic [DIM_W-1:0] d);
      return (d != 4'd0) && (d <= 4'(MAX_DIM));
   endfunction

endpackage

// File: rtl/macarray_ctrl_if.sv
// Host, buffer-port and array-control signals of the MAC array controller.
interface macarray_ctrl_if;
   import macarray_pkg::*;

   logic [11:0]         mnt;
   logic                start;
   logic                busy;
   logic                done;
   logic                err;
   logic                en_w;
   logic [2:0]          addr_w;
   logic                en_i;
   logic [2:0]          addr_i;
   logic                en_o;
   logic                rw_o;
   logic [ADDR_O_W-1:0] addr_o;
   logic [DIM_W-1:0]    cfg_m;
   logic [DIM_W-1:0]    cfg_n;
   logic [DIM_W-1:0]    cfg_t;
   logic                acc_clr;
   logic                w_load;
   logic [2:0]          w_row;
   logic                i_valid;
   logic [2:0]          i_row;
   logic [2:0]          rd_row;
   logic                rd_half;

   modport master (
      input  mnt, start,
      output busy, done, err, en_w, addr_w, en_i, addr_i, en_o, rw_o, addr_o,
             cfg_m, cfg_n, cfg_t, acc_clr, w_load, w_row, i_valid, i_row,
             rd_row, rd_half
   );

   modport slave (
      output mnt, start,
      input  busy, done, err, en_w, addr_w, en_i, addr_i, en_o, rw_o, addr_o,
             cfg_m, cfg_n, cfg_t, acc_clr, w_load, w_row, i_valid, i_row,
             rd_row, rd_half
   );

endinterface

// File: rtl/macarray_loop_cnt.sv
// 3-bit loop counter: load clears the count and captures the last index;
// stepping past the last index wraps to 0 so the count idles at 0 between loops.
module macarray_loop_cnt (
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic [2:0] limit,
   input  logic       inc,
   output logic [2:0] cnt,
   output logic       last
);

   logic [2:0] limit_r;

   // count and limit registers
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt     <= 3'd0;
         limit_r <= 3'd0;
      end else if (load) begin
         cnt     <= 3'd0;
         limit_r <= limit;
      end else if (inc) begin
         cnt     <= last ? 3'd0 : cnt + 3'd1;
      end else begin
         cnt     <= cnt;
      end
   end

   assign last = (cnt == limit_r);

endmodule

// File: rtl/macarray_ctrl.sv
// Sequencing controller for the 8x8 int8 MAC array: load weights, stream inputs,
// drain the pipeline and write result words, with every output driven from a flop.
module macarray_ctrl
   import macarray_pkg::*;
#(
   parameter int PIPE_LAT = 2
) (
   input  logic           clk,
   input  logic           rst,
   macarray_ctrl_if.master bus
);

   state_t           state_r, state_nx_s;
   logic [DIM_W-1:0] m_s, n_s, t_s;
   logic             legal_s, accept_s, err_s;
   logic             w_inc_s, i_inc_s, o_inc_s;
   logic             w_last_s, i_last_s, o_last_s;
   logic [2:0]       w_cnt_s, i_cnt_s, o_cnt_s;
   logic [2:0]       drain_r;
   logic             drain_done_s, wpr2_s, half_r;
   logic [DIM_W-1:0] cfg_m_r, cfg_n_r, cfg_t_r;
   logic             busy_r, done_r, err_r, acc_clr_r;
   logic             en_w_r, en_i_r, en_o_r, w_load_r, i_valid_r;
   logic [2:0]       w_row_r, i_row_r;

   assign m_s      = bus.mnt[MNT_M_LSB +: DIM_W];
   assign n_s      = bus.mnt[MNT_N_LSB +: DIM_W];
   assign t_s      = bus.mnt[MNT_T_LSB +: DIM_W];
   assign legal_s  = dim_legal(m_s) && dim_legal(n_s) && dim_legal(t_s);
   assign accept_s = (state_r == ST_IDLE) && bus.start && legal_s;
   assign err_s    = (state_r == ST_IDLE) && bus.start && !legal_s;

   assign wpr2_s       = (cfg_t_r > 4'd4);
   assign drain_done_s = (drain_r == 3'(PIPE_LAT));
   assign w_inc_s      = (state_r == ST_LOAD_W);
   assign i_inc_s      = (state_r == ST_STREAM);
   // with two words per row the row only advances after the upper half
   assign o_inc_s      = (state_r == ST_WRITE) && (!wpr2_s || half_r);

   macarray_loop_cnt u_w_cnt (
      .clk(clk), .rst(rst), .load(accept_s), .limit(3'(n_s - 4'd1)),
      .inc(w_inc_s), .cnt(w_cnt_s), .last(w_last_s)
   );

   macarray_loop_cnt u_i_cnt (
      .clk(clk), .rst(rst), .load(accept_s), .limit(3'(m_s - 4'd1)),
      .inc(i_inc_s), .cnt(i_cnt_s), .last(i_last_s)
   );

   macarray_loop_cnt u_o_cnt (
      .clk(clk), .rst(rst), .load(accept_s), .limit(3'(m_s - 4'd1)),
      .inc(o_inc_s), .cnt(o_cnt_s), .last(o_last_s)
   );

   // next-state decode
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         ST_IDLE:   if (accept_s)            state_nx_s = ST_LOAD_W; else state_nx_s = ST_IDLE;
         ST_LOAD_W: if (w_last_s)            state_nx_s = ST_STREAM; else state_nx_s = ST_LOAD_W;
         ST_STREAM: if (i_last_s)            state_nx_s = ST_DRAIN;  else state_nx_s = ST_STREAM;
         ST_DRAIN:  if (drain_done_s)        state_nx_s = ST_WRITE;  else state_nx_s = ST_DRAIN;
         ST_WRITE:  if (o_inc_s && o_last_s) state_nx_s = ST_FIN;    else state_nx_s = ST_WRITE;
         ST_FIN:    state_nx_s = ST_IDLE;
         default:   state_nx_s = ST_IDLE;
      endcase
   end

   // state, phase counters, configuration and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= ST_IDLE;
         drain_r   <= 3'd0;
         half_r    <= 1'b0;
         cfg_m_r   <= 4'd0;
         cfg_n_r   <= 4'd0;
         cfg_t_r   <= 4'd0;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
         err_r     <= 1'b0;
         acc_clr_r <= 1'b0;
         en_w_r    <= 1'b0;
         en_i_r    <= 1'b0;
         en_o_r    <= 1'b0;
         w_load_r  <= 1'b0;
         w_row_r   <= 3'd0;
         i_valid_r <= 1'b0;
         i_row_r   <= 3'd0;
      end else begin
         state_r   <= state_nx_s;
         drain_r   <= ((state_r == ST_DRAIN) && !drain_done_s) ? drain_r + 3'd1 : 3'd0;
         half_r    <= ((state_r == ST_WRITE) && wpr2_s) ? ~half_r : 1'b0;
         if (accept_s) begin
            cfg_m_r <= m_s;
            cfg_n_r <= n_s;
            cfg_t_r <= t_s;
         end
         busy_r    <= (state_nx_s != ST_IDLE);
         done_r    <= (state_nx_s == ST_FIN);
         err_r     <= err_s;
         acc_clr_r <= accept_s;
         en_w_r    <= (state_nx_s == ST_LOAD_W);
         en_i_r    <= (state_nx_s == ST_STREAM);
         en_o_r    <= (state_nx_s == ST_WRITE);
         // buffer data returns one cycle after the read enable
         w_load_r  <= en_w_r;
         w_row_r   <= w_cnt_s;
         i_valid_r <= en_i_r;
         i_row_r   <= i_cnt_s;
      end
   end

   assign bus.busy    = busy_r;
   assign bus.done    = done_r;
   assign bus.err     = err_r;
   assign bus.acc_clr = acc_clr_r;
   assign bus.en_w    = en_w_r;
   assign bus.addr_w  = w_cnt_s;
   assign bus.en_i    = en_i_r;
   assign bus.addr_i  = i_cnt_s;
   assign bus.en_o    = en_o_r;
   assign bus.rw_o    = en_o_r;
   assign bus.addr_o  = {o_cnt_s, half_r};
   assign bus.rd_row  = o_cnt_s;
   assign bus.rd_half = half_r;
   assign bus.w_load  = w_load_r;
   assign bus.w_row   = w_row_r;
   assign bus.i_valid = i_valid_r;
   assign bus.i_row   = i_row_r;
   assign bus.cfg_m   = cfg_m_r;
   assign bus.cfg_n   = cfg_n_r;
   assign bus.cfg_t   = cfg_t_r;

endmodule
